// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, size helpers and the byte/column
// transforms (S-box computed from the GF(2^8) inverse plus affine map).
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        FINAL = 2'd3
    } fsm_t;

    localparam int   NB       = 4;
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] v;
        v = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(v);
    endfunction

    function automatic logic [7:0] rcon(input int j);
        case (j)
            1:       return 8'h01;
            2:       return 8'h02;
            3:       return 8'h04;
            4:       return 8'h08;
            5:       return 8'h10;
            6:       return 8'h20;
            7:       return 8'h40;
            8:       return 8'h80;
            9:       return 8'h1b;
            10:      return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte n (MSB first) sits at row n%4, column n/4
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3,
                a0 ^ gf_mul(a1, 8'h02) ^ gf_mul(a2, 8'h03) ^ a3,
                a0 ^ a1 ^ gf_mul(a2, 8'h02) ^ gf_mul(a3, 8'h03),
                gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ gf_mul(a3, 8'h02)};
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round_sel.sv
// Round-key and datapath selector: picks rk[i] for the current phase/round/mode
// and chooses which candidate next state the core registers.
module aes_round_sel import aes_pkg::*; #(
    parameter int NR = 12
) (
    input  logic [128*(NR+1)-1:0] rk_flat,
    input  logic [3:0]            round,
    input  logic                  mode,
    input  logic                  init_phase,
    input  logic                  final_phase,
    input  logic [127:0]          cand_init,
    input  logic [127:0]          cand_enc_round,
    input  logic [127:0]          cand_enc_final,
    input  logic [127:0]          cand_dec_round,
    input  logic [127:0]          cand_dec_final,
    output logic [127:0]          rk,
    output logic [127:0]          state_next
);

    logic [3:0] rk_idx;

    always_comb begin
        rk_idx = round;
        if (final_phase)
            rk_idx = (mode == MODE_ENC) ? 4'(NR) : 4'd0;
        else if (init_phase)
            rk_idx = (mode == MODE_ENC) ? 4'd0 : 4'(NR);
        else if (mode == MODE_DEC)
            rk_idx = 4'(NR) - round;
    end

    assign rk = rk_flat[128*int'(rk_idx) +: 128];

    always_comb begin
        state_next = cand_init;
        if (!init_phase) begin
            if (final_phase)
                state_next = (mode == MODE_DEC) ? cand_dec_final : cand_enc_final;
            else
                state_next = (mode == MODE_DEC) ? cand_dec_round : cand_enc_round;
        end
    end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES core, one round per clock, start/done handshake with latched inputs.
// Optional monitor taps (mon_byte, mon_round) are built only when AES_MON_EN is defined.
module aes_iter_core import aes_pkg::*; #(
    parameter int NK = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    input  logic [32*NK-1:0] key_in,
    input  logic [127:0]    data_in,
    output logic            busy,
    output logic            done,
    output logic [127:0]    data_out
`ifdef AES_MON_EN
   ,output logic [7:0]      mon_byte,
    output logic [3:0]      mon_round
`endif
);

    localparam int NR = nr_of(NK);
    localparam int NW = NB * (NR + 1);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_iter_core: NK must be 4, 6 or 8");
    end

    fsm_t                  fsm;
    logic [32*NK-1:0]      key_q;
    logic                  mode_q;
    logic [127:0]          state_q;
    logic [3:0]            round_q;
    logic [128*(NR+1)-1:0] rk_flat;
    logic [127:0]          rk;
    logic [127:0]          state_next;
    logic [127:0]          enc_sr;
    logic [127:0]          dec_sr;

    // Whole schedule from the latched key only, so input changes mid-block are harmless
    always_comb begin : key_exp
        logic [31:0] ws [NW];
        logic [31:0] t;
        ws      = '{default: '0};
        t       = '0;
        rk_flat = '0;
        for (int i = 0; i < NK; i++)
            ws[i] = key_q[32*(NK-i)-1 -: 32];
        for (int i = NK; i < NW; i++) begin
            t = ws[i-1];
            if (i % NK == 0)
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / NK), 24'h000000};
            else if (NK > 6 && i % NK == 4)
                t = sub_word(t);
            ws[i] = ws[i-NK] ^ t;
        end
        for (int j = 0; j <= NR; j++)
            rk_flat[128*j +: 128] = {ws[4*j], ws[4*j+1], ws[4*j+2], ws[4*j+3]};
    end

    assign enc_sr = shift_rows(sub_bytes(state_q));
    assign dec_sr = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk;

    aes_round_sel #(.NR(NR)) u_round_sel (
        .rk_flat        (rk_flat),
        .round          (round_q),
        .mode           (mode_q),
        .init_phase     (fsm == INIT),
        .final_phase    (fsm == FINAL),
        .cand_init      (state_q ^ rk),
        .cand_enc_round (mix_columns(enc_sr) ^ rk),
        .cand_enc_final (enc_sr ^ rk),
        .cand_dec_round (inv_mix_columns(dec_sr)),
        .cand_dec_final (dec_sr),
        .rk             (rk),
        .state_next     (state_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm      <= IDLE;
            key_q    <= '0;
            mode_q   <= 1'b0;
            state_q  <= '0;
            round_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        key_q   <= key_in;
                        state_q <= data_in;
                        mode_q  <= mode;
                        round_q <= '0;
                        busy    <= 1'b1;
                        fsm     <= INIT;
                    end
                end
                INIT: begin
                    state_q <= state_next;
                    round_q <= 4'd1;
                    fsm     <= ROUND;
                end
                ROUND: begin
                    state_q <= state_next;
                    round_q <= round_q + 4'd1;
                    if (round_q == 4'(NR - 1))
                        fsm <= FINAL;
                end
                FINAL: begin
                    state_q  <= state_next;
                    data_out <= state_next;
                    round_q  <= '0;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    fsm      <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

`ifdef AES_MON_EN
    assign mon_byte  = state_q[7:0];
    assign mon_round = round_q;
`else
    // Monitor taps absent: no extra ports or registers.
`endif

endmodule
